// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding an LSB-first serializer.
// Each bit is held for P clock cycles; back-to-back frames leave no idle gap.
module uart_tx #(
  parameter int P     = 10416,
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       wr,
  output logic       full,
  output logic       empty,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(P);
  localparam logic [CW-1:0] LAST = CW'(P - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, idx_n;
  logic [7:0]    shift_reg, shift_n;
  logic          tx_n, done_n;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr && !full;
  assign busy  = (state != IDLE) || !empty;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= idx_n;
      shift_reg <= shift_n;
      tx        <= tx_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = bit_idx;
    shift_n = shift_reg;
    tx_n    = tx;
    done_n  = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = shift_reg[0];
          state_n = DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = shift_reg >> 1;
            idx_n   = bit_idx + 3'd1;
            tx_n    = shift_reg[1];
          end
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n  = '0;
          done_n = 1'b1;
          // Chain straight into the next start bit so streamed bytes have no gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: begin
        cnt_n   = '0;
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with P=16, DEPTH=4; a line decoder checks every
// received frame against a queue of bytes pushed when writes are accepted.
module tb_uart_tx;

  localparam int P     = 16;
  localparam int DEPTH = 4;

  logic       clock;
  logic       reset_n;
  logic [7:0] data;
  logic       wr;
  logic       full, empty, tx, busy, done;

  int checks = 0;
  int errors = 0;
  int rx_count = 0;
  int done_count = 0;
  logic [7:0] exp_q [$];

  uart_tx #(.P(P), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .data(data), .wr(wr),
    .full(full), .empty(empty), .tx(tx), .busy(busy), .done(done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    data = b;
    wr   = 1'b1;
    exp_q.push_back(b);
    @(negedge clock);
    wr   = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      @(negedge clock);
      n++;
    end
    check({tag, " idle reached"}, busy, 1'b0);
  endtask

  // Starts on the negedge of start-bit cycle 0, ends on the negedge of cycle 10P.
  task automatic expect_frame(input logic [7:0] b, input logic first_done);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10 * P; i++) begin
      check($sformatf("frame tx cyc %0d", i), tx, bits[i / P]);
      check($sformatf("frame done cyc %0d", i), done, (i == 0) ? first_done : 1'b0);
      check("frame busy", busy, 1'b1);
      @(negedge clock);
    end
  endtask

  // Line decoder sampling mid-bit, independent of the DUT's internals.
  initial begin
    int mcnt;
    int k;
    bit act;
    logic [7:0] msh;
    act  = 0;
    mcnt = 0;
    msh  = '0;
    forever begin
      @(negedge clock);
      if (done === 1'b1) done_count++;
      if (reset_n !== 1'b1) begin
        act = 0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act  = 1;
          mcnt = 0;
        end
      end else begin
        mcnt++;
        if (mcnt % P == P / 2) begin
          k = mcnt / P;
          if (k == 0) begin
            check("rx start bit", tx, 1'b0);
          end else if (k <= 8) begin
            msh[k-1] = tx;
          end else begin
            check("rx stop bit", tx, 1'b1);
            check("rx frame expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("rx byte", msh, exp_q.pop_front());
            rx_count++;
            act = 0;
          end
        end
      end
    end
  end

  initial begin
    int n;
    int dc;
    reset_n = 1'b0;
    wr      = 1'b0;
    data    = '0;
    repeat (3) @(negedge clock);
    check("reset tx", tx, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset full", full, 1'b0);
    check("reset empty", empty, 1'b1);
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] idle line");
    for (int i = 0; i < 1000; i++) begin
      check("idle tx", tx, 1'b1);
      check("idle busy", busy, 1'b0);
      check("idle done", done, 1'b0);
      @(negedge clock);
    end

    $display("[TB] single byte 0xA5");
    write_byte(8'hA5);
    check("single latency tx", tx, 1'b1);
    check("single busy", busy, 1'b1);
    @(negedge clock);
    expect_frame(8'hA5, 1'b0);
    check("single done pulse", done, 1'b1);
    check("single tx after", tx, 1'b1);
    check("single busy after", busy, 1'b0);
    check("single empty after", empty, 1'b1);
    @(negedge clock);
    check("single done cleared", done, 1'b0);
    check("single rx count", rx_count, 1);
    check("single done count", done_count, 1);

    $display("[TB] back-to-back 0x00, 0xFF");
    data = 8'h00; wr = 1'b1; exp_q.push_back(8'h00);
    @(negedge clock);
    data = 8'hFF; exp_q.push_back(8'hFF);
    @(negedge clock);
    wr = 1'b0;
    expect_frame(8'h00, 1'b0);
    expect_frame(8'hFF, 1'b1);
    check("b2b final done", done, 1'b1);
    check("b2b final busy", busy, 1'b0);
    @(negedge clock);
    check("b2b rx count", rx_count, 3);
    check("b2b done count", done_count, 3);

    $display("[TB] overflow");
    for (int i = 0; i < 6; i++) begin
      data = 8'(i + 1);
      wr   = 1'b1;
      if (i < 5) exp_q.push_back(8'(i + 1));
      @(negedge clock);
      check($sformatf("ovf full after write %0d", i), full, (i >= 4) ? 1'b1 : 1'b0);
      check("ovf empty", empty, 1'b0);
    end
    wr = 1'b0;
    n = 0;
    while (full === 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("ovf full release cycles", n, 156);
    check("ovf full cleared", full, 1'b0);
    wait_idle(6 * 10 * P, "ovf");
    @(negedge clock);
    check("ovf rx count", rx_count, 8);
    check("ovf done count", done_count, 8);

    $display("[TB] pointer wrap stream");
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (full === 1'b1 && n < 400) begin
        @(negedge clock);
        n++;
      end
      check("wrap full wait bound", n < 400, 1'b1);
      write_byte(8'(8'h30 + i));
    end
    wait_idle(12 * 10 * P, "wrap");
    @(negedge clock);
    check("wrap rx count", rx_count, 18);
    check("wrap done count", done_count, 18);

    $display("[TB] reset mid-frame");
    data = 8'hC3; wr = 1'b1;
    @(negedge clock);
    wr = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("rst frame started", tx, 1'b0);
    repeat (4 * P + P / 2) @(negedge clock);
    check("rst busy before", busy, 1'b1);
    dc = done_count;
    reset_n = 1'b0;
    #1;
    check("rst tx", tx, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst empty", empty, 1'b1);
    check("rst full", full, 1'b0);
    check("rst done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst hold tx", tx, 1'b1);
      check("rst hold done", done, 1'b0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    check("rst no done pulse", done_count, dc);
    write_byte(8'h5A);
    wait_idle(12 * P, "rst");
    @(negedge clock);
    check("rst rx count", rx_count, 19);
    check("rst done count", done_count, dc + 1);

    repeat (2 * P) @(negedge clock);
    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
